// File: rtl/raster_to_block.sv
// raster_to_block: raster pixels -> 8x8 block rows via a ping-pong band buffer; RASTER_TO_BLOCK_FRAME_CHECK_EN enables frame_err.
// Latency: last pixel of a band at edge N -> first of IMG_W contiguous beats at edge N+2.
// Backpressure: none; every in_valid pixel is taken and a drain always finishes before the next band completes.
module raster_to_block #(
    parameter int W_IO  = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [W_IO-1:0]      in_data,
    input  logic                 in_sof,
    output logic                 out_valid,
    output logic [7:0][W_IO-1:0] out_data,
    output logic                 out_sob,
    output logic                 out_eob,
    output logic                 out_sof,
    output logic                 frame_err
);
    localparam int WPL   = IMG_W / 8;
    localparam int DEPTH = 8 * WPL;
    localparam int NBAND = IMG_H / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(IMG_W);
    localparam int BKW   = $clog2(WPL);
    localparam int NBW   = (NBAND > 1) ? $clog2(NBAND) : 1;

    typedef logic [7:0][W_IO-1:0] word_t;
    typedef enum logic {IDLE, DRAIN} state_t;

    logic [CW-1:0]  col, ecol;
    logic [2:0]     line, eline;
    logic [NBW-1:0] band, eband;
    logic           sof_px, last_col, band_done, frame_end;
    logic           fill_bank, drain_bank, fill_sof, drain_sof;

    word_t          mem [0:1][0:DEPTH-1];
    word_t          pack, wr_word, rd_word;
    logic           wr_en;
    logic [AW-1:0]  wr_addr, rd_addr;

    state_t         state, state_n;
    logic [BKW-1:0] blk;
    logic [2:0]     row;
    logic           rd_vld, rd_sob, rd_eob, rd_sof;

    // An in_sof pixel is treated as col 0 / line 0 / band 0 regardless of the counters.
    assign sof_px    = in_valid && in_sof;
    assign ecol      = sof_px ? '0 : col;
    assign eline     = sof_px ? '0 : line;
    assign eband     = sof_px ? '0 : band;
    assign last_col  = (ecol == CW'(IMG_W - 1));
    assign band_done = in_valid && last_col && (eline == 3'd7);
    assign frame_end = band_done && (eband == NBW'(NBAND - 1));

    assign wr_en   = in_valid && (ecol[2:0] == 3'd7);
    assign wr_addr = AW'(eline) * AW'(WPL) + AW'(ecol >> 3);
    assign rd_addr = AW'(row) * AW'(WPL) + AW'(blk);

    always_comb begin
        wr_word    = pack;
        wr_word[7] = in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            line       <= '0;
            band       <= '0;
            fill_bank  <= 1'b0;
            drain_bank <= 1'b0;
            fill_sof   <= 1'b0;
            drain_sof  <= 1'b0;
        end else if (in_valid) begin
            if (ecol == '0 && eline == 3'd0)
                fill_sof <= in_sof;
            if (last_col) begin
                col <= '0;
                if (eline == 3'd7) begin
                    line <= '0;
                    band <= frame_end ? '0 : eband + NBW'(1);
                end else begin
                    line <= eline + 3'd1;
                    band <= eband;
                end
            end else begin
                col  <= ecol + CW'(1);
                line <= eline;
                band <= eband;
            end
            if (band_done) begin
                drain_bank <= fill_bank;
                fill_bank  <= ~fill_bank;
                drain_sof  <= fill_sof;
            end
        end
    end

    // Band storage and pixel packing carry no reset.
    always_ff @(posedge clk) begin
        if (in_valid)
            pack[ecol[2:0]] <= in_data;
        if (wr_en)
            mem[fill_bank][wr_addr] <= wr_word;
        rd_word <= mem[drain_bank][rd_addr];
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (band_done) state_n = DRAIN;
            DRAIN:   if (blk == BKW'(WPL - 1) && row == 3'd7) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            blk   <= '0;
            row   <= '0;
        end else begin
            state <= state_n;
            if (state == DRAIN) begin
                row <= row + 3'd1;
                if (row == 3'd7)
                    blk <= blk + BKW'(1);
            end else begin
                row <= '0;
                blk <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld    <= 1'b0;
            rd_sob    <= 1'b0;
            rd_eob    <= 1'b0;
            rd_sof    <= 1'b0;
            out_valid <= 1'b0;
            out_sob   <= 1'b0;
            out_eob   <= 1'b0;
            out_sof   <= 1'b0;
            out_data  <= '0;
        end else begin
            rd_vld    <= (state == DRAIN);
            rd_sob    <= (state == DRAIN) && (row == 3'd0);
            rd_eob    <= (state == DRAIN) && (row == 3'd7);
            rd_sof    <= (state == DRAIN) && (row == 3'd0) && (blk == '0) && drain_sof;
            out_valid <= rd_vld;
            out_sob   <= rd_sob;
            out_eob   <= rd_eob;
            out_sof   <= rd_sof;
            if (rd_vld)
                out_data <= rd_word;
        end
    end

`ifdef RASTER_TO_BLOCK_FRAME_CHECK_EN
    localparam int TOTAL = IMG_W * IMG_H;
    localparam int FW    = $clog2(TOTAL + 1);

    logic [FW-1:0] px_cnt;
    logic          err_trunc, err_nosof;

    // A count of TOTAL marks a completed frame that has not yet been followed by a pixel.
    assign err_trunc = sof_px && (px_cnt != '0) && (px_cnt != FW'(TOTAL));
    assign err_nosof = in_valid && !in_sof && (px_cnt == FW'(TOTAL));

    always_ff @(posedge clk) begin
        if (rst) begin
            px_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_trunc || err_nosof;
            if (in_valid)
                px_cnt <= (in_sof || px_cnt == FW'(TOTAL)) ? FW'(1) : px_cnt + FW'(1);
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_raster_to_block.sv
// Directed bench for raster_to_block at IMG_W=16, IMG_H=16 (two bands per frame).
module tb_raster_to_block;
    localparam int W_IO  = 8;
    localparam int IMG_W = 16;
    localparam int IMG_H = 16;
`ifdef RASTER_TO_BLOCK_FRAME_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef logic [7:0][W_IO-1:0] word_t;
    typedef struct {
        word_t d;
        logic  sob;
        logic  eob;
        logic  sof;
        int    cyc;
    } beat_t;
    typedef struct {
        int id;
        int pre_px;     // stray pixels sent before the frame
        bit sof;        // in_sof on the frame's first pixel
        int gap_max;    // max idle cycles between pixels
        int off;        // pixel value offset
        int exp_beats;
        bit exp_sof0;   // out_sof expected on beat 0
        int exp_err;    // frame_err pulses with the check compiled in
    } vec_t;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_sof;
    logic [W_IO-1:0] in_data;
    logic            out_valid, out_sob, out_eob, out_sof, frame_err;
    word_t           out_data;

    int    cyc = 0;
    int    err_seen = 0;
    int    n_chk = 0;
    int    n_err = 0;
    beat_t beats[$];
    vec_t  vecs[4];

    raster_to_block #(.W_IO(W_IO), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sob   (out_sob),
        .out_eob   (out_eob),
        .out_sof   (out_sof),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        beat_t bt;
        if (out_valid === 1'b1) begin
            bt.d   = out_data;
            bt.sob = out_sob;
            bt.eob = out_eob;
            bt.sof = out_sof;
            bt.cyc = cyc;
            beats.push_back(bt);
        end
        if (frame_err === 1'b1)
            err_seen++;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pix(input int off, input int ln, input int c);
        return 8'((ln * 16 + c + off) & 255);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_px(input logic [7:0] d, input logic s, output int edge_no);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        edge_no  = cyc + 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int nlines, input bit sof, input int gap_max, input int off,
                              input int pre_px, output int le0, output int le1);
        int e;
        le0 = -100;
        le1 = -100;
        for (int p = 0; p < pre_px; p++)
            send_px(8'(p * 7 + 1), 1'b0, e);
        for (int ln = 0; ln < nlines; ln++) begin
            for (int c = 0; c < IMG_W; c++) begin
                send_px(pix(off, ln, c), sof && ln == 0 && c == 0, e);
                if (c == IMG_W - 1 && ln == 7)  le0 = e;
                if (c == IMG_W - 1 && ln == 15) le1 = e;
                if (gap_max > 0)
                    repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            end
        end
    endtask

    // Beat j: band j/16, block (j%16)/8, row j%8; band k's burst starts two edges after its last pixel.
    task automatic check_beats(input int id, input int exp_n, input int off, input bit sof0,
                               input int le0, input int le1);
        chk($sformatf("v%0d beat_count", id), 64'(beats.size()), 64'(exp_n));
        for (int j = 0; j < exp_n && j < beats.size(); j++) begin
            int    k, jj, b, r, ecyc;
            word_t w;
            k  = j / 16;
            jj = j % 16;
            b  = jj / 8;
            r  = jj % 8;
            for (int i = 0; i < 8; i++)
                w[i] = pix(off, 8 * k + r, 8 * b + i);
            ecyc = ((k == 0) ? le0 : le1) + 2 + jj;
            chk($sformatf("v%0d beat%0d data", id, j), 64'(beats[j].d), 64'(w));
            chk($sformatf("v%0d beat%0d sob_eob_sof_cycle", id, j),
                {29'd0, beats[j].sob, beats[j].eob, beats[j].sof, 32'(beats[j].cyc)},
                {29'd0, r == 0, r == 7, sof0 && j == 0, 32'(ecyc)});
        end
    endtask

    task automatic run_vec(input vec_t v);
        int le0, le1;
        beats.delete();
        err_seen = 0;
        send_frame(IMG_H, v.sof, v.gap_max, v.off, v.pre_px, le0, le1);
        repeat (IMG_W + 8) @(posedge clk); #1;
        check_beats(v.id, v.exp_beats, v.off, v.exp_sof0, le0, le1);
        chk($sformatf("v%0d frame_err_pulses", v.id), 64'(err_seen),
            CHK_EN ? 64'(v.exp_err) : 64'd0);
    endtask

    initial begin : main
        int   le0, le1;
        vec_t post;
        //           id pre sof  gap off beats sof0 err
        vecs[0] = '{0, 0,  1'b1, 0, 0,  32, 1'b1, 0};
        vecs[1] = '{1, 0,  1'b1, 5, 3,  32, 1'b1, 0};
        vecs[2] = '{2, 20, 1'b1, 0, 7,  32, 1'b1, 2};
        vecs[3] = '{3, 0,  1'b0, 0, 11, 32, 1'b0, 1};
        post    = '{5, 0,  1'b1, 0, 9,  32, 1'b1, 0};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk); #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_sob",   64'(out_sob),   64'd0);
        chk("reset out_eob",   64'(out_eob),   64'd0);
        chk("reset out_sof",   64'(out_sof),   64'd0);
        chk("reset frame_err", 64'(frame_err), 64'd0);
        chk("reset out_data",  64'(out_data),  64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++)
            run_vec(vecs[v]);

        // Reset while beat 5 of band 0 is on the output.
        beats.delete();
        err_seen = 0;
        send_frame(8, 1'b1, 0, 5, 0, le0, le1);
        repeat (7) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_drain out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_drain out_sob",   64'(out_sob),   64'd0);
        repeat (IMG_W + 8) @(posedge clk); #1;
        check_beats(4, 6, 5, 1'b1, le0, 0);
        chk("rst_mid_drain frame_err_pulses", 64'(err_seen), 64'd0);

        run_vec(post);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
